instr_encoder_serializer: RTL and testbench

- Transmit-side counterpart of the instruction decoder.
- Accepts one instruction as discrete fields plus a format code, packs it into 1–3 halfwords using the pkg_instr_enc bit positions, and emits the halfwords serially, hw0 first.
- Feeds the boot/debug loader path that writes instruction memory, and the bench stimulus generator for the decoder.
- Valid/ready on both sides; back-to-back instructions supported with no bubble.

---
 rtl/instr_encoder_serializer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_instr_encoder_serializer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_serializer.sv
// -----------------------------------------------------------------------------
// instr_encoder_serializer
// Packs one instruction (discrete fields plus a format code) into 1..3
// halfwords and streams them out hw0 first. This is the transmit-side partner
// of the instruction decoder. It feeds the boot/debug loader path and the
// decoder stimulus generator.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready instruction handshake (in_ready is combinational)
//   in_fmt            0 NONE, 1 IMM16, 2 IMM32, 3 BLK2, 4 MULTI3, 5..7 illegal
//   in_group..in_num  instruction fields, sampled only on an accept cycle
//   out_valid/out_ready halfword handshake
//   out_hw            current halfword
//   out_first/out_last  out_hw is hw0 / the final halfword
//   err_illegal_fmt   one-cycle pulse after an illegal format is consumed
// -----------------------------------------------------------------------------

`ifndef CPU_HALF_WORD_MSB_POS
`define CPU_HALF_WORD_MSB_POS 15
`endif

// Halfword field layout shared by the encoder and the decoder.
package pkg_instr_enc;
    localparam int unsigned HW_W_C  = `CPU_HALF_WORD_MSB_POS + 1;
    localparam int unsigned REG_W_C = 4;
    localparam int unsigned NUM_W_C = 2;

    localparam logic [2:0] FMT_NONE   = 3'd0;
    localparam logic [2:0] FMT_IMM16  = 3'd1;
    localparam logic [2:0] FMT_IMM32  = 3'd2;
    localparam logic [2:0] FMT_BLK2   = 3'd3;
    localparam logic [2:0] FMT_MULTI3 = 3'd4;

    // hw0: group[15:14], spare[13:12], oper[11:8], ra[7:4], rb[3:0]
    typedef struct packed {
        logic [1:0]         enc_group;
        logic [1:0]         spare;
        logic [3:0]         oper;
        logic [REG_W_C-1:0] ra_index;
        logic [REG_W_C-1:0] rb_index;
    } hw0_t;

    // Four register indices: rc,rd,re,rf in hw1 of MULTI3.
    typedef struct packed {
        logic [REG_W_C-1:0] reg_0;
        logic [REG_W_C-1:0] reg_1;
        logic [REG_W_C-1:0] reg_2;
        logic [REG_W_C-1:0] reg_3;
    } multi_t;

    // Two register indices plus block-move rx/num.
    // Used for hw1 of BLK2 (rc,rd) and hw2 of MULTI3 (rg,rh).
    typedef struct packed {
        logic [REG_W_C-1:0] reg_0;
        logic [REG_W_C-1:0] reg_1;
        logic [REG_W_C-1:0] rx_index;
        logic [1:0]         spare;
        logic [NUM_W_C-1:0] num_regs;
    } blk_t;
endpackage

module instr_encoder_serializer
    import pkg_instr_enc::*;
#(
    parameter int unsigned HW_W      = `CPU_HALF_WORD_MSB_POS + 1,
    parameter int unsigned REG_IDX_W = 4,
    parameter int unsigned NUM_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [1:0]           in_group,
    input  logic [3:0]           in_oper,
    input  logic [REG_IDX_W-1:0] in_ra,
    input  logic [REG_IDX_W-1:0] in_rb,
    input  logic [31:0]          in_imm,
    input  logic [REG_IDX_W-1:0] in_rc,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [REG_IDX_W-1:0] in_re,
    input  logic [REG_IDX_W-1:0] in_rf,
    input  logic [REG_IDX_W-1:0] in_rg,
    input  logic [REG_IDX_W-1:0] in_rh,
    input  logic [REG_IDX_W-1:0] in_rx,
    input  logic [NUM_W-1:0]     in_num,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [HW_W-1:0]      out_hw,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 err_illegal_fmt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      len_q, len_d;
    logic [HW_W-1:0] hw0_q, hw0_d;
    logic [HW_W-1:0] hw1_q, hw1_d;
    logic [HW_W-1:0] hw2_q, hw2_d;
    logic            err_q, err_d;

    hw0_t            pk_h0;
    multi_t          pk_m;
    blk_t            pk_b;
    logic [HW_W-1:0] pk_hw0, pk_hw1, pk_hw2;
    logic [1:0]      pk_len;
    logic            fmt_legal_c;

    logic            emit_c;
    logic            last_c;
    logic            accept_c;

    // Pack the presented fields. Everything is computed every cycle and only
    // captured on an accept.
    always_comb begin
        pk_h0           = '0;
        pk_h0.enc_group = in_group;
        pk_h0.oper      = in_oper;
        pk_h0.ra_index  = REG_W_C'(in_ra);
        pk_h0.rb_index  = REG_W_C'(in_rb);

        pk_m       = '0;
        pk_m.reg_0 = REG_W_C'(in_rc);
        pk_m.reg_1 = REG_W_C'(in_rd);
        pk_m.reg_2 = REG_W_C'(in_re);
        pk_m.reg_3 = REG_W_C'(in_rf);

        pk_b          = '0;
        pk_b.rx_index = REG_W_C'(in_rx);
        pk_b.num_regs = NUM_W_C'(in_num);

        pk_hw0      = HW_W'(pk_h0);
        pk_hw1      = '0;
        pk_hw2      = '0;
        pk_len      = 2'd1;
        fmt_legal_c = 1'b1;

        case (in_fmt)
            FMT_NONE: begin
                pk_len = 2'd1;
            end
            FMT_IMM16: begin
                pk_len = 2'd2;
                pk_hw1 = HW_W'(in_imm[15:0]);
            end
            FMT_IMM32: begin
                pk_len = 2'd3;
                pk_hw1 = HW_W'(in_imm[31:16]);
                pk_hw2 = HW_W'(in_imm[15:0]);
            end
            FMT_BLK2: begin
                pk_len     = 2'd2;
                pk_b.reg_0 = REG_W_C'(in_rc);
                pk_b.reg_1 = REG_W_C'(in_rd);
                pk_hw1     = HW_W'(pk_b);
            end
            FMT_MULTI3: begin
                pk_len     = 2'd3;
                pk_hw1     = HW_W'(pk_m);
                pk_b.reg_0 = REG_W_C'(in_rg);
                pk_b.reg_1 = REG_W_C'(in_rh);
                pk_hw2     = HW_W'(pk_b);
            end
            default: begin
                fmt_legal_c = 1'b0;
            end
        endcase
    end

    // Handshake decode. During the final halfword handshake, in_ready rises so
    // the next instruction can load with no bubble.
    assign emit_c   = (state_q == ST_EMIT);
    assign last_c   = (idx_q == (len_q - 2'd1));
    assign in_ready = !emit_c || (out_ready && last_c);
    assign accept_c = in_valid && in_ready;

    assign out_valid       = emit_c;
    assign out_first       = emit_c && (idx_q == 2'd0);
    assign out_last        = emit_c && last_c;
    assign err_illegal_fmt = err_q;

    // Output halfword select. The select is forced to zero while idle.
    always_comb begin
        out_hw = '0;
        if (emit_c) begin
            case (idx_q)
                2'd0:    out_hw = hw0_q;
                2'd1:    out_hw = hw1_q;
                default: out_hw = hw2_q;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        hw0_d   = hw0_q;
        hw1_d   = hw1_q;
        hw2_d   = hw2_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (fmt_legal_c) begin
                        hw0_d   = pk_hw0;
                        hw1_d   = pk_hw1;
                        hw2_d   = pk_hw2;
                        len_d   = pk_len;
                        idx_d   = 2'd0;
                        state_d = ST_EMIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (accept_c) begin
                    // accept_c here implies the last halfword was taken
                    if (fmt_legal_c) begin
                        hw0_d   = pk_hw0;
                        hw1_d   = pk_hw1;
                        hw2_d   = pk_hw2;
                        len_d   = pk_len;
                        idx_d   = 2'd0;
                        state_d = ST_EMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (out_ready) begin
                    if (last_c) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            len_q   <= 2'd1;
            hw0_q   <= '0;
            hw1_q   <= '0;
            hw2_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            hw0_q   <= hw0_d;
            hw1_q   <= hw1_d;
            hw2_q   <= hw2_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder_serializer.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_serializer
// Directed bench for instr_encoder_serializer. Each scenario task drives its
// stimulus and checks the observed output against hand-computed values.
// Per-cycle observations are packed as
// {out_valid, out_first, out_last, in_ready, out_hw}.
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_instr_encoder_serializer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [1:0]  in_group;
    logic [3:0]  in_oper;
    logic [3:0]  in_ra, in_rb, in_rc, in_rd, in_re, in_rf, in_rg, in_rh, in_rx;
    logic [31:0] in_imm;
    logic [1:0]  in_num;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_hw;
    logic        out_first;
    logic        out_last;
    logic        err_illegal_fmt;

    int tests_run    = 0;
    int tests_failed = 0;

    instr_encoder_serializer #(
        .HW_W      (16),
        .REG_IDX_W (4),
        .NUM_W     (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_fmt          (in_fmt),
        .in_group        (in_group),
        .in_oper         (in_oper),
        .in_ra           (in_ra),
        .in_rb           (in_rb),
        .in_imm          (in_imm),
        .in_rc           (in_rc),
        .in_rd           (in_rd),
        .in_re           (in_re),
        .in_rf           (in_rf),
        .in_rg           (in_rg),
        .in_rh           (in_rh),
        .in_rx           (in_rx),
        .in_num          (in_num),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_hw          (out_hw),
        .out_first       (out_first),
        .out_last        (out_last),
        .err_illegal_fmt (err_illegal_fmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [19:0] obs();
        return {out_valid, out_first, out_last, in_ready, out_hw};
    endfunction

    task automatic clear_fields();
        in_valid = 1'b0;
        in_fmt   = 3'd0;
        in_group = 2'd0;
        in_oper  = 4'd0;
        {in_ra, in_rb, in_rc, in_rd, in_re, in_rf, in_rg, in_rh, in_rx} = '0;
        in_imm   = 32'd0;
        in_num   = 2'd0;
    endtask

    task automatic set_hdr(input logic [2:0] fmt, input logic [1:0] grp,
                           input logic [3:0] op, input logic [3:0] ra,
                           input logic [3:0] rb);
        in_fmt   = fmt;
        in_group = grp;
        in_oper  = op;
        in_ra    = ra;
        in_rb    = rb;
    endtask

    task automatic test_reset();
        logic [19:0] o;
        rst       = 1'b1;
        out_ready = 1'b1;
        clear_fields();
        repeat (2) @(negedge clk);
        #1;
        o = obs();
        tests_run++;
        if (o !== 20'h10000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h", o, 20'h10000);
        end
        tests_run++;
        if (err_illegal_fmt !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err: got %b expected 0", err_illegal_fmt);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        o = obs();
        tests_run++;
        if (o !== 20'h10000) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got %h expected %h", o, 20'h10000);
        end
    endtask

    task automatic test_none();
        logic [19:0] o;
        logic [15:0] cap;
        logic [19:0] exp_v [2];
        exp_v = '{20'hF4325, 20'h10000};
        cap = '0;
        @(negedge clk);
        set_hdr(3'd0, 2'd1, 4'd3, 4'd2, 4'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            o = obs();
            if (i == 0) cap = out_hw;
            tests_run++;
            if (o !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL none_cyc%0d: got %h expected %h", i, o, exp_v[i]);
            end
        end
        tests_run++;
        if ({cap[15:14], cap[11:8], cap[7:4], cap[3:0]} !== {2'd1, 4'd3, 4'd2, 4'd5}) begin
            tests_failed++;
            $display("FAIL none_decode: got %h expected %h",
                     {cap[15:14], cap[11:8], cap[7:4], cap[3:0]}, {2'd1, 4'd3, 4'd2, 4'd5});
        end
    endtask

    task automatic test_imm32();
        logic [19:0] o;
        logic [15:0] cap [4];
        logic [19:0] exp_v [4];
        exp_v = '{20'hC8A1F, 20'h8DEAD, 20'hBBEEF, 20'h10000};
        @(negedge clk);
        set_hdr(3'd2, 2'd2, 4'hA, 4'h1, 4'hF);
        in_imm   = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            o = obs();
            cap[i] = out_hw;
            tests_run++;
            if (o !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL imm32_cyc%0d: got %h expected %h", i, o, exp_v[i]);
            end
        end
        tests_run++;
        if ({cap[1], cap[2]} !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL imm32_decode: got %h expected %h", {cap[1], cap[2]}, 32'hDEAD_BEEF);
        end
        tests_run++;
        if ({cap[0][15:14], cap[0][11:0]} !== {2'd2, 12'hA1F}) begin
            tests_failed++;
            $display("FAIL imm32_hdr_decode: got %h expected %h",
                     {cap[0][15:14], cap[0][11:0]}, {2'd2, 12'hA1F});
        end
    endtask

    task automatic test_imm16_stall();
        logic [19:0] o;
        logic [15:0] cap1;
        logic [31:0] s16;
        logic        rdy_seq [5];
        logic [19:0] exp_v [5];
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_v   = '{20'hC0100, 20'hA8001, 20'hA8001, 20'hB8001, 20'h10000};
        cap1 = '0;
        @(negedge clk);
        out_ready = 1'b1;
        set_hdr(3'd1, 2'd0, 4'd1, 4'd0, 4'd0);
        in_imm   = 32'h0000_8001;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = rdy_seq[i];
            // fields change mid-instruction and must be ignored
            if (i == 1) in_imm = 32'h0000_0000;
            #1;
            o = obs();
            if (i == 1) cap1 = out_hw;
            tests_run++;
            if (o !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL imm16_stall_cyc%0d: got %h expected %h", i, o, exp_v[i]);
            end
        end
        s16 = {{16{cap1[15]}}, cap1};
        tests_run++;
        if (s16 !== 32'hFFFF_8001) begin
            tests_failed++;
            $display("FAIL imm16_s16_decode: got %h expected %h", s16, 32'hFFFF_8001);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [19:0] o;
        logic [15:0] cap [6];
        logic [19:0] exp_v [6];
        logic [29:0] m3;
        logic [13:0] b2;
        exp_v = '{20'hCC546, 20'h81234, 20'hB5672, 20'hC4C89, 20'hBABC3, 20'h10000};
        @(negedge clk);
        out_ready = 1'b1;
        set_hdr(3'd4, 2'd3, 4'd5, 4'd4, 4'd6);
        {in_rc, in_rd, in_re, in_rf} = {4'd1, 4'd2, 4'd3, 4'd4};
        {in_rg, in_rh, in_rx}        = {4'd5, 4'd6, 4'd7};
        in_num   = 2'd2;
        in_valid = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idle_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // present BLK2 now; held until the MULTI3 last beat takes it
                set_hdr(3'd3, 2'd1, 4'hC, 4'h8, 4'h9);
                {in_rc, in_rd, in_re, in_rf} = {4'hA, 4'hB, 4'hF, 4'hF};
                {in_rg, in_rh, in_rx}        = {4'hF, 4'hF, 4'hC};
                in_num = 2'd3;
            end
            if (i == 3) in_valid = 1'b0;
            #1;
            o = obs();
            cap[i] = out_hw;
            tests_run++;
            if (o !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL b2b_cyc%0d: got %h expected %h", i, o, exp_v[i]);
            end
        end
        m3 = {cap[1][15:12], cap[1][11:8], cap[1][7:4], cap[1][3:0],
              cap[2][15:12], cap[2][11:8], cap[2][7:4], cap[2][1:0]};
        tests_run++;
        if (m3 !== {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 2'd2}) begin
            tests_failed++;
            $display("FAIL multi3_decode: got %h expected %h",
                     m3, {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 2'd2});
        end
        b2 = {cap[4][15:12], cap[4][11:8], cap[4][7:4], cap[4][1:0]};
        tests_run++;
        if (b2 !== {4'hA, 4'hB, 4'hC, 2'd3}) begin
            tests_failed++;
            $display("FAIL blk2_decode: got %h expected %h", b2, {4'hA, 4'hB, 4'hC, 2'd3});
        end
    endtask

    task automatic test_illegal();
        logic [19:0] o;
        logic [1:0]  ev;
        logic [1:0]  exp_e [2];
        logic [19:0] exp_v [2];
        exp_e = '{2'b10, 2'b00};
        exp_v = '{20'hF8731, 20'h10000};
        @(negedge clk);
        clear_fields();
        in_fmt   = 3'd6;
        in_group = 2'd3;
        in_valid = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            ev = {err_illegal_fmt, out_valid};
            tests_run++;
            if (ev !== exp_e[i]) begin
                tests_failed++;
                $display("FAIL illegal_err_cyc%0d: got %b expected %b", i, ev, exp_e[i]);
            end
        end
        set_hdr(3'd0, 2'd2, 4'd7, 4'd3, 4'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            o = obs();
            tests_run++;
            if (o !== exp_v[i] || err_illegal_fmt !== 1'b0) begin
                tests_failed++;
                $display("FAIL after_illegal_cyc%0d: got %h err %b expected %h err 0",
                         i, o, err_illegal_fmt, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] o;
        logic [15:0] cap1;
        logic [19:0] exp_a [2];
        logic [19:0] exp_b [3];
        exp_a = '{20'hC0201, 20'h81234};
        exp_b = '{20'hC4111, 20'hB7FFF, 20'h10000};
        cap1 = '0;
        @(negedge clk);
        out_ready = 1'b1;
        clear_fields();
        set_hdr(3'd2, 2'd0, 4'd2, 4'd0, 4'd1);
        in_imm   = 32'h1234_5678;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            o = obs();
            tests_run++;
            if (o !== exp_a[i]) begin
                tests_failed++;
                $display("FAIL rstmid_pre_cyc%0d: got %h expected %h", i, o, exp_a[i]);
            end
        end
        @(posedge clk);
        #2;
        o = obs();
        tests_run++;
        if (o !== 20'hB5678) begin
            tests_failed++;
            $display("FAIL rstmid_hw2_before_rst: got %h expected %h", o, 20'hB5678);
        end
        rst = 1'b1;
        #1;
        o = obs();
        tests_run++;
        if (o !== 20'h10000) begin
            tests_failed++;
            $display("FAIL rstmid_async_drop: got %h expected %h", o, 20'h10000);
        end
        @(negedge clk);
        rst = 1'b0;
        set_hdr(3'd1, 2'd1, 4'd1, 4'd1, 4'd1);
        in_imm   = 32'h0000_7FFF;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            o = obs();
            if (i == 1) cap1 = out_hw;
            tests_run++;
            if (o !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL rstmid_post_cyc%0d: got %h expected %h", i, o, exp_b[i]);
            end
        end
        tests_run++;
        if ({{16{cap1[15]}}, cap1} !== 32'h0000_7FFF) begin
            tests_failed++;
            $display("FAIL rstmid_s16_decode: got %h expected %h",
                     {{16{cap1[15]}}, cap1}, 32'h0000_7FFF);
        end
    endtask

    initial begin
        test_reset();
        test_none();
        test_imm32();
        test_imm16_stall();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
